sample_fetch_arbiter: RTL

//  Shares one sample-memory read port between NUM_OSCILLATORS voice oscillators.
//  It sits between the per-voice oscillators and the sample BRAM.

---
 rtl/sample_fetch_arbiter_if.sv | 29 ++
 rtl/sample_fetch_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/sample_fetch_arbiter_if.sv
// Bundle of voice-side request/return signals and the sample-memory read port
// shared by the fetch arbiter. The slave modport is the arbiter itself. The
// master modport is the environment around it: the voice oscillators plus the
// sample BRAM.
interface sample_fetch_arbiter_if #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int ADDR_WIDTH      = 17,
  parameter int SAMPLE_WIDTH    = 16
);
  logic [NUM_OSCILLATORS-1:0]                 is_on;
  logic [NUM_OSCILLATORS-1:0]                 req_in;
  logic [NUM_OSCILLATORS-1:0][ADDR_WIDTH-1:0] req_addr_in;
  logic [NUM_OSCILLATORS-1:0]                 grant_out;
  logic                                       mem_en_out;
  logic [ADDR_WIDTH-1:0]                      mem_addr_out;
  logic [SAMPLE_WIDTH-1:0]                    mem_data_in;
  logic [SAMPLE_WIDTH-1:0]                    data_out;
  logic [NUM_OSCILLATORS-1:0]                 data_valid_out;

  modport slave (
    input  is_on, req_in, req_addr_in, mem_data_in,
    output grant_out, mem_en_out, mem_addr_out, data_out, data_valid_out
  );

  modport master (
    output is_on, req_in, req_addr_in, mem_data_in,
    input  grant_out, mem_en_out, mem_addr_out, data_out, data_valid_out
  );
endinterface

// File: rtl/sample_fetch_arbiter.sv
// Round-robin arbiter that shares one sample-memory read port between the
// voice oscillators. At most one read is issued per cycle. Each returned word
// is tagged back to its requester after a fixed latency. Reads belonging to
// voices that switch off while in flight are silently dropped.
module sample_fetch_arbiter #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int ADDR_WIDTH      = 17,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int READ_LATENCY    = 2
) (
  input logic                   clk_in,
  input logic                   rst_in,
  sample_fetch_arbiter_if.slave bus
);
  localparam int TAG_WIDTH = $clog2(NUM_OSCILLATORS);
  localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_OSCILLATORS - 1);
  localparam logic [TAG_WIDTH:0]   NUM_EXT  = (TAG_WIDTH + 1)'(NUM_OSCILLATORS);

  logic [NUM_OSCILLATORS-1:0] grant_q;
  logic                       mem_en_q;
  logic [ADDR_WIDTH-1:0]      mem_addr_q;
  logic [SAMPLE_WIDTH-1:0]    data_q;
  logic [NUM_OSCILLATORS-1:0] data_valid_q;

  logic [TAG_WIDTH-1:0]       rr_ptr;
  logic [TAG_WIDTH-1:0]       issue_tag;
  logic [NUM_OSCILLATORS-1:0] elig;
  logic [TAG_WIDTH-1:0]       winner;
  logic                       found;
  logic [TAG_WIDTH:0]         cand_sum;

  logic [READ_LATENCY-1:0]    slot_valid;
  logic [TAG_WIDTH-1:0]       slot_tag [READ_LATENCY];

  assign bus.grant_out      = grant_q;
  assign bus.mem_en_out     = mem_en_q;
  assign bus.mem_addr_out   = mem_addr_q;
  assign bus.data_out       = data_q;
  assign bus.data_valid_out = data_valid_q;

  // Find the first eligible voice after the pointer, wrapping to voice 0.
  // A voice that currently holds a grant is masked so it cannot be granted twice.
  always_comb begin
    elig     = bus.req_in & bus.is_on & ~grant_q;
    found    = 1'b0;
    winner   = rr_ptr;
    cand_sum = '0;
    for (int k = 1; k <= NUM_OSCILLATORS; k++) begin
      cand_sum = {1'b0, rr_ptr} + (TAG_WIDTH + 1)'(k);
      if (cand_sum >= NUM_EXT) begin
        cand_sum = cand_sum - NUM_EXT;
      end
      if (!found && elig[cand_sum[TAG_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = cand_sum[TAG_WIDTH-1:0];
      end
    end
  end

  // Register the grant, the memory read and the pointer. The address holds when idle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      issue_tag  <= '0;
      rr_ptr     <= LAST_IDX;
    end else begin
      mem_en_q <= found;
      if (found) begin
        grant_q    <= NUM_OSCILLATORS'(1) << winner;
        mem_addr_q <= bus.req_addr_in[winner];
        issue_tag  <= winner;
        rr_ptr     <= winner;
      end else begin
        grant_q <= '0;
      end
    end
  end

  // Track in-flight reads and return registered data to the owning voice.
  // Any cycle in which the owner is off clears the slot, so the word is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_valid   <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        slot_tag[k] <= '0;
      end
      data_q       <= '0;
      data_valid_q <= '0;
    end else begin
      slot_valid[0] <= mem_en_q & bus.is_on[issue_tag];
      slot_tag[0]   <= issue_tag;
      for (int k = 1; k < READ_LATENCY; k++) begin
        slot_valid[k] <= slot_valid[k-1] & bus.is_on[slot_tag[k-1]];
        slot_tag[k]   <= slot_tag[k-1];
      end
      if (slot_valid[READ_LATENCY-1] && bus.is_on[slot_tag[READ_LATENCY-1]]) begin
        data_q       <= bus.mem_data_in;
        data_valid_q <= NUM_OSCILLATORS'(1) << slot_tag[READ_LATENCY-1];
      end else begin
        data_valid_q <= '0;
      end
    end
  end
endmodule
